// File: rtl/decode_issue_queue.sv
// Decode front-end: pre-decodes fetched words into a DEPTH-entry FIFO and issues
// them to execute, stalling after a syscall/eret until the exception logic is done.
module decode_issue_queue #(
  parameter int DEPTH      = 4,
  parameter bit ENABLE_CP0 = 1'b1
) (
  input  logic                       in_clk,
  input  logic                       in_rst_n,
  input  logic                       in_is_valid,
  input  logic [31:0]                in_is,
  output logic                       out_is_ready,
  input  logic                       in_issue_ready,
  input  logic                       in_flush,
  input  logic                       in_serial_done,
  output logic                       out_valid,
  output logic [31:0]                out_is,
  output logic                       out_special,
  output logic [5:0]                 out_op,
  output logic                       out_J,
  output logic                       out_JW,
  output logic                       out_JR,
  output logic                       out_branch,
  output logic                       out_MemWrite,
  output logic                       out_syscall,
  output logic                       out_cp0,
  output logic                       out_eret,
  output logic [$clog2(DEPTH):0]     out_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef struct packed {
    logic       special;
    logic [5:0] op;
    logic       j;
    logic       jw;
    logic       jr;
    logic       branch;
    logic       mem_write;
    logic       syscall;
    logic       cp0;
    logic       eret;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] rs;
    opc         = w[31:26];
    fn          = w[5:0];
    rs          = w[25:21];
    d.special   = (opc == 6'h00);
    d.op        = d.special ? fn : opc;
    d.j         = (opc == 6'h02) || (opc == 6'h03);
    d.jw        = (opc == 6'h03) || (d.special && fn == 6'h09);
    d.jr        = d.special && (fn == 6'h08 || fn == 6'h09);
    d.branch    = (opc == 6'h01) || (opc == 6'h04) || (opc == 6'h05);
    d.mem_write = (opc == 6'h28) || (opc == 6'h29) || (opc == 6'h2B);
    d.syscall   = d.special && (fn == 6'h0C);
    // With CP0 disabled these encodings flow through as ordinary instructions.
    d.cp0       = ENABLE_CP0 && (opc == 6'h10) && (rs == 5'h00 || rs == 5'h04);
    d.eret      = ENABLE_CP0 && (opc == 6'h10) && (rs == 5'h10) && (fn == 6'h18);
    return d;
  endfunction

  logic [31:0]   word_q [DEPTH];
  dec_t          dec_q  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [0:0]    state;

  logic empty, full, enq, deq;
  dec_t head;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign out_is_ready = in_rst_n && !full && !in_flush;
  assign out_valid    = (state == RUN) && !empty;
  assign enq          = in_is_valid && out_is_ready;
  assign deq          = out_valid && in_issue_ready;
  assign head         = empty ? '0 : dec_q[rd_ptr];

  always_ff @(posedge in_clk) begin
    if (enq) begin
      word_q[wr_ptr] <= in_is;
      dec_q[wr_ptr]  <= decode(in_is);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= RUN;
    end else if (in_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= RUN;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A serialising instruction blocks issue from the edge it leaves the queue.
      if (state == RUN && deq && (head.syscall || head.eret)) state <= WAIT;
      else if (state == WAIT && in_serial_done)               state <= RUN;
    end
  end

  assign out_is       = empty ? 32'h0 : word_q[rd_ptr];
  assign out_special  = head.special;
  assign out_op       = head.op;
  assign out_J        = head.j;
  assign out_JW       = head.jw;
  assign out_JR       = head.jr;
  assign out_branch   = head.branch;
  assign out_MemWrite = head.mem_write;
  assign out_syscall  = head.syscall;
  assign out_cp0      = head.cp0;
  assign out_eret     = head.eret;
  assign out_count    = count;
endmodule
